timer_sched: RTL and testbench

//  Shares one 16-bit free-running timer (t_en / t_valid / t_out) between NREQ requesters.

---
 rtl/timer_sched.sv | 161 ++++++++++++++++
 tb/tb_timer_sched.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_sched.sv
// timer_sched: round-robin sharing of one free-running W-bit timer among NREQ
// requesters. Each grant arms the timer, latches a base count and pulses done
// to the owner once (t_out - base) mod 2^W reaches the requested duration.
// Optional build macro: TIMER_SCHED_ABORT_EN (owner dropping req cancels the
// interval without a done pulse).
module timer_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] dur,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic              t_en,
  input  logic              t_valid,
  input  logic [W-1:0]      t_out
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   rr_ptr, ptr_n;
  logic [PW-1:0]   owner, owner_n;
  logic [W-1:0]    base, base_n;
  logic [W-1:0]    dur_q, dur_n;
  logic [NREQ-1:0] gnt_n, done_n;
  logic            t_en_n, busy_n;

  logic            found;
  logic [PW-1:0]   win;
  logic [PW:0]     idx;
  logic [PW:0]     nxt;
  logic [NREQ-1:0] win_oh, owner_oh;
  logic [W-1:0]    dur_w;
  logic [W-1:0]    elapsed;
  logic            abort;

  // Round-robin search: first requester at or after the pointer, wrapping once.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
    nxt = {1'b0, win} + (PW+1)'(1);
    if (nxt >= (PW+1)'(NREQ)) nxt = '0;
    win_oh        = '0;
    win_oh[win]   = 1'b1;
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
    dur_w   = dur[32'(win)*W +: W];
    elapsed = t_out - base;
`ifdef TIMER_SCHED_ABORT_EN
    abort = !req[owner];
`else
    abort = 1'b0;
`endif
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n = state;
    ptr_n   = rr_ptr;
    owner_n = owner;
    base_n  = base;
    dur_n   = dur_q;
    gnt_n   = gnt;
    done_n  = '0;
    t_en_n  = t_en;
    unique case (state)
      S_IDLE: begin
        if (found) begin
          ptr_n   = nxt[PW-1:0];
          owner_n = win;
          if (dur_w != '0) begin
            gnt_n   = win_oh;
            dur_n   = dur_w;
            t_en_n  = 1'b1;
            state_n = S_ARM;
          end else begin
            // Zero-length interval completes at arbitration, timer untouched.
            done_n  = win_oh;
            state_n = S_DRAIN;
          end
        end
      end
      S_ARM: begin
        if (abort) begin
          t_en_n  = 1'b0;
          gnt_n   = '0;
          state_n = S_DRAIN;
        end else if (t_valid) begin
          base_n  = t_out;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          t_en_n  = 1'b0;
          gnt_n   = '0;
          state_n = S_DRAIN;
        end else if (t_valid && (elapsed == dur_q)) begin
          t_en_n  = 1'b0;
          gnt_n   = '0;
          done_n  = owner_oh;
          state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // One idle cycle lets the timer's trailing t_valid drain before re-arbitration.
        t_en_n  = 1'b0;
        gnt_n   = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      base   <= '0;
      dur_q  <= '0;
      gnt    <= '0;
      done   <= '0;
      t_en   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      rr_ptr <= ptr_n;
      owner  <= owner_n;
      base   <= base_n;
      dur_q  <= dur_n;
      gnt    <= gnt_n;
      done   <= done_n;
      t_en   <= t_en_n;
      busy   <= busy_n;
    end
  end

endmodule

// File: tb/tb_timer_sched.sv
// Directed self-checking bench for timer_sched with a simple timer model:
// t_valid follows t_en by one cycle and the count advances while t_valid is high.
module tb_timer_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] dur;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic        t_en;
  logic        t_valid = 1'b0;
  logic [15:0] tcount  = 16'h0000;
  logic        preload = 1'b0;
  logic [15:0] pre_val = 16'h0000;
  logic [15:0] t_prev;

  int n_checks = 0;
  int n_fail   = 0;

  timer_sched #(.NREQ(4), .W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .dur     (dur),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy),
    .t_en    (t_en),
    .t_valid (t_valid),
    .t_out   (tcount)
  );

  always #5 clk = ~clk;

  // Timer model: never reset by the scheduler.
  always @(posedge clk) begin
    t_valid <= t_en;
    if (preload) tcount <= pre_val;
    else if (t_valid) tcount <= tcount + 16'd1;
  end

  task automatic step();
    t_prev = tcount;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    dur = '0;
    #2;
    n_checks++;
    if ({gnt, done, busy, t_en} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_async: got gnt=%b done=%b busy=%b t_en=%b want all 0", gnt, done, busy, t_en);
    end
    preload = 1'b1;
    pre_val = 16'h0100;
    step();
    step();
    preload = 1'b0;
    n_checks++;
    if ({gnt, done, busy, t_en} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_held: got gnt=%b done=%b busy=%b t_en=%b want all 0", gnt, done, busy, t_en);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if ({gnt, done, busy, t_en} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got gnt=%b done=%b busy=%b t_en=%b want all 0", gnt, done, busy, t_en);
    end
  endtask

  task automatic test_single();
    int got = -1;
    int npulse = 0;
    logic [3:0] dval = '0;
    do_reset();
    req = 4'b0001;
    dur[15:0] = 16'd5;
    step();
    n_checks++;
    if (gnt !== 4'b0001 || t_en !== 1'b1 || busy !== 1'b1 || done !== 4'b0) begin
      n_fail++;
      $display("FAIL single_grant: got gnt=%b t_en=%b busy=%b done=%b want 0001 1 1 0000", gnt, t_en, busy, done);
    end
    dur[15:0] = 16'd1;  // owner's dur change after grant must be ignored
    for (int k = 1; k <= 12; k++) begin
      step();
      if (done !== 4'b0) begin
        npulse++;
        if (got < 0) begin
          got  = k;
          dval = done;
          req  = '0;
        end
      end
    end
    n_checks++;
    if (got !== 7) begin
      n_fail++;
      $display("FAIL single_latency: got %0d cycles want 7", got);
    end
    n_checks++;
    if (dval !== 4'b0001 || npulse !== 1) begin
      n_fail++;
      $display("FAIL single_done: got done=%b pulses=%0d want 0001 1", dval, npulse);
    end
    n_checks++;
    if (busy !== 1'b0 || gnt !== 4'b0 || t_en !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release: got busy=%b gnt=%b t_en=%b want 0 0000 0", busy, gnt, t_en);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010};
    logic [3:0] gseq [5];
    logic [3:0] dseq [5];
    int gcyc [5];
    int dcyc [5];
    int ng = 0;
    int nd = 0;
    logic [3:0] gprev = '0;
    do_reset();
    dur = {16'd2, 16'd2, 16'd2, 16'd2};
    req = 4'b1011;
    for (int k = 0; k < 200 && (ng < 5 || nd < 5); k++) begin
      step();
      if (gnt !== 4'b0 && gprev === 4'b0 && ng < 5) begin
        gseq[ng] = gnt;
        gcyc[ng] = k;
        ng++;
      end
      if (done !== 4'b0 && nd < 5) begin
        dseq[nd] = done;
        dcyc[nd] = k;
        nd++;
      end
      gprev = gnt;
    end
    req = '0;
    n_checks++;
    if (ng !== 5 || nd !== 5) begin
      n_fail++;
      $display("FAIL rr_timeout: got %0d grants %0d dones want 5 5", ng, nd);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (gseq[i] !== exp_seq[i]) begin
          n_fail++;
          $display("FAIL rr_grant%0d: got %b want %b", i, gseq[i], exp_seq[i]);
        end
        n_checks++;
        if (dseq[i] !== exp_seq[i]) begin
          n_fail++;
          $display("FAIL rr_done%0d: got %b want %b", i, dseq[i], exp_seq[i]);
        end
      end
      n_checks++;
      if (dcyc[0] - gcyc[0] !== 4) begin
        n_fail++;
        $display("FAIL rr_latency: got %0d want 4", dcyc[0] - gcyc[0]);
      end
      n_checks++;
      if (gcyc[1] - dcyc[0] !== 2) begin
        n_fail++;
        $display("FAIL rr_regrant_gap: got %0d want 2", gcyc[1] - dcyc[0]);
      end
    end
    for (int k = 0; k < 30 && busy !== 1'b0; k++) step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_zero_dur();
    logic ten_seen = 1'b0;
    int extra = 0;
    do_reset();
    dur = {16'd9, 16'd0, 16'd9, 16'd9};
    req = 4'b0100;
    step();
    n_checks++;
    if (done !== 4'b0100 || gnt !== 4'b0 || t_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done: got done=%b gnt=%b t_en=%b busy=%b want 0100 0000 0 1", done, gnt, t_en, busy);
    end
    req = '0;
    step();
    n_checks++;
    if (done !== 4'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_clear: got done=%b busy=%b want 0000 0", done, busy);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      if (t_en === 1'b1) ten_seen = 1'b1;
      if (done !== 4'b0) extra++;
    end
    n_checks++;
    if (ten_seen !== 1'b0 || extra !== 0) begin
      n_fail++;
      $display("FAIL zero_quiet: got t_en_seen=%b extra_done=%0d want 0 0", ten_seen, extra);
    end
  endtask

  task automatic test_wrap();
    int got = -1;
    logic [15:0] t_at = '0;
    logic [3:0] dval = '0;
    preload = 1'b1;
    pre_val = 16'hFFFD;
    step();
    preload = 1'b0;
    dur[63:48] = 16'd4;
    req = 4'b1000;
    step();
    n_checks++;
    if (gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL wrap_grant: got %b want 1000", gnt);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      if (done !== 4'b0 && got < 0) begin
        got  = k;
        t_at = t_prev;
        dval = done;
        req  = '0;
      end
    end
    n_checks++;
    if (got !== 6 || dval !== 4'b1000) begin
      n_fail++;
      $display("FAIL wrap_done: got cycle=%0d done=%b want 6 1000", got, dval);
    end
    n_checks++;
    if (t_at !== 16'h0001) begin
      n_fail++;
      $display("FAIL wrap_tout: got %h want 0001", t_at);
    end
  endtask

  task automatic test_reset_mid();
    int extra = 0;
    do_reset();
    dur[31:16] = 16'd10;
    req = 4'b0010;
    step();
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL rstmid_grant: got %b want 0010", gnt);
    end
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    #1;
    n_checks++;
    if (gnt !== 4'b0 || t_en !== 1'b0 || busy !== 1'b0 || done !== 4'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: got gnt=%b t_en=%b busy=%b done=%b want 0000 0 0 0000", gnt, t_en, busy, done);
    end
    step();
    rst = 1'b0;
    req = '0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (done !== 4'b0 || gnt !== 4'b0) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL rstmid_nodone: got %0d active cycles want 0", extra);
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    dur[31:16] = 16'd6;
    req = 4'b0010;
    step();
    for (int k = 0; k < 4; k++) step();
    req = '0;
`ifdef TIMER_SCHED_ABORT_EN
    begin
      int extra = 0;
      step();
      n_checks++;
      if (t_en !== 1'b0 || gnt !== 4'b0 || done !== 4'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL abort_cut: got t_en=%b gnt=%b done=%b busy=%b want 0 0000 0000 1", t_en, gnt, done, busy);
      end
      step();
      n_checks++;
      if (busy !== 1'b0 || done !== 4'b0) begin
        n_fail++;
        $display("FAIL abort_idle: got busy=%b done=%b want 0 0000", busy, done);
      end
      for (int k = 0; k < 10; k++) begin
        step();
        if (done !== 4'b0) extra++;
      end
      n_checks++;
      if (extra !== 0) begin
        n_fail++;
        $display("FAIL abort_nodone: got %0d done pulses want 0", extra);
      end
    end
`else
    begin
      int got = -1;
      logic [3:0] dval = '0;
      for (int k = 1; k <= 12; k++) begin
        step();
        if (done !== 4'b0 && got < 0) begin
          got  = k;
          dval = done;
        end
      end
      n_checks++;
      if (got !== 4 || dval !== 4'b0010) begin
        n_fail++;
        $display("FAIL drop_ignored: got cycle=%0d done=%b want 4 0010", got, dval);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_dur();
    test_wrap();
    test_reset_mid();
    test_req_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
